bist_march_sequencer: RTL
=========================

# bist_march_sequencer

Memory-BIST control stage that sits directly upstream of the pattern generator. It drives the generator's submit, shift and clear strobes, walks the address space, writes each generated pattern word into the memory under test, and reads it back. Read data is compared against the regenerated pattern, and pass/fail status and a first-failure record are reported to the top-level BIST wrapper.

## Interface
- `aw`, default `` `ADDR_WIDTH ``: address width; N = 2^aw words.
- `dw`, default `` `DATA_WIDTH ``: data word width.
- `np`, default 160: patterns per run (32 gray counts × 5 column selects).
- `ew`, default 16: error counter width.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `start_in` in 1: run request; sampled in IDLE/DONE only.
- `busy_out` out 1: high from start acceptance until DONE.
- `done_out` out 1: high in DONE until the next start or reset.
- `pass_out` out 1: equals `done_out & ~fail_out`.
- `gen_clr_out` out 1: clear pulse to the generator's reset.
- `sbmt_out` out 1: submit pulse to the generator.
- `shft_out` out 1: shift pulse to the generator.
- `addr_out` out aw: address to the memory and the generator's address input.
- `ptrn_in` in dw: pattern word from the generator.
- `mem_we_out` out 1: memory write enable.
- `mem_re_out` out 1: memory read enable.
- `mem_wdata_out` out dw: memory write data.
- `mem_rdata_in` in dw: memory read data, valid 1 cycle after `mem_re_out`.
- `fail_out` out 1: sticky mismatch flag.
- `fail_addr_out` out aw: address of the first mismatch.
- `fail_pat_out` out 8: pattern index of the first mismatch.
- `err_cnt_out` out ew: mismatch count, saturating at all-ones.

## Operation
- The generator is edge-triggered on its strobes. Every strobe is a registered 1-cycle pulse followed by at least 1 low cycle. `ptrn_in` is used no earlier than 1 cycle after a strobe's high cycle.
- Tile mirror `tm` (0..4) tracks the generator's tile count.
  - Cleared by CLR.
  - Incremented mod 5 on every `shft_out` pulse.
- Pad count p = (5 − N mod 5) mod 5.

States:
- **IDLE**
  - `start_in` → CLR_H; clear `fail`, `err_cnt`, `pat`, `addr`, `tm`.
- **CLR_H**: `gen_clr_out`=1 → CLR_L.
- **CLR_L**: strobes low → W_ACC.
- **W_ACC**: `mem_we_out`=1, `mem_wdata_out`=`ptrn_in` → W_ADV.
- **W_ADV**: `shft_out`=1, `addr`+1, `tm`+1.
  - If `addr` was N−1: `addr` wraps to 0 → W_PAD.
  - Otherwise → W_ACC.
- **W_PAD**: alternating high/low `shft_out` cycles, each high cycle incrementing `tm`, until `tm`==0.
  - With p=0, exactly 1 low cycle.
  - → R_ACC.
- **R_ACC**: `mem_re_out`=1; register `exp`←`ptrn_in` → R_CMP.
- **R_CMP**: compare `mem_rdata_in` with `exp`.
  - `shft_out`=1, `addr`+1, `tm`+1.
  - Wrap → R_PAD, else → R_ACC.
- **R_PAD**: as W_PAD → NEXT.
- **NEXT**: `sbmt_out`=1.
  - If `pat`==np−1 → DONE.
  - Otherwise `pat`+1 → W_ACC. W_ACC is the required low cycle after the pulse.
- **DONE**
  - `start_in` → CLR_H, with the clears listed under IDLE.

Mismatch handling in R_CMP:
- Set `fail_out`.
- `err_cnt` +1, saturating.
- On the first mismatch of the run only, capture `fail_addr_out`=`addr` and `fail_pat_out`=`pat`.

Other rules:
- `start_in` while busy is ignored.
- `rst` at any point, including mid-run, returns to IDLE on the next edge.

## Timing
- Reset values: all outputs 0; state IDLE.
- Start accepted on edge e0; CLR_H occupies the cycle after e0.
- Per pattern: 4N + 4p + 1 cycles.
- `done_out` rises 2 + np·(4N + 4p + 1) cycles after e0.
  - aw=5: 22,562 cycles.
  - aw=3 (N=8, p=2): 2 + 41·np cycles.
- Compare latency: `exp` is registered in R_ACC; the check occurs in R_CMP, 1 cycle later. Error outputs update the cycle after R_CMP.
- Strobes never stay high for 2 consecutive cycles.

## Structure
- Shared package/defines:
  - state encodings;
  - tile period constant 5;
  - `` `ADDR_WIDTH `` and `` `DATA_WIDTH ``;
  - default np.
- One sub-module, `bist_err_log`, holds the error bookkeeping:
  - sticky fail flag;
  - first-fail capture;
  - saturating counter;
  - clear input.
- The sequencer FSM and counters stay in the top module.

## Test plan
- aw=3, np=2, ideal memory model wired to a real pattern generator, start pulse → `done_out` at cycle 84; `pass_out`=1; `err_cnt_out`=0.
- Same setup, bit 0 forced stuck-at-1 at address 5 → `fail_out`=1; `fail_addr_out`=5; `fail_pat_out`=index of the first pattern with bit 0 = 0 at address 5; `err_cnt_out` = that count.
- Strobe monitor over a full run → no strobe high on consecutive cycles.
  - `shft_out` pulses per pattern = 2(N+p) = 20.
  - `sbmt_out` pulses per run = np.
- `rst` asserted mid-read-pass → the next cycle has all outputs 0 and state IDLE; a fresh start completes normally.
- `start_in` held high through the run → exactly 1 run. From DONE, a new start clears `fail`/`err_cnt` and reruns.
- `ew`=2, every read corrupted → `err_cnt_out` saturates at 3; first-fail address=0, pattern=0.

Source files
------------

// File: rtl/bist_march_sequencer_pkg.sv
// bist_march_sequencer_pkg: sequencer states, tile period and default sizes.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
package bist_march_sequencer_pkg;
    typedef enum logic [3:0] {
        IDLE, CLR_H, CLR_L, W_ACC, W_ADV, W_PAD, R_ACC, R_CMP, R_PAD, NEXT, DONE
    } state_t;
    localparam int TILE   = 5;
    localparam int NP_DEF = 160;
endpackage

// File: rtl/bist_err_log.sv
// bist_err_log: sticky fail flag, first-failure capture and saturating error count.
module bist_err_log #(
    parameter int aw = 5,
    parameter int ew = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          chk,
    input  logic          mis,
    input  logic [aw-1:0] addr,
    input  logic [7:0]    pat,
    output logic          fail,
    output logic [aw-1:0] fail_addr,
    output logic [7:0]    fail_pat,
    output logic [ew-1:0] err_cnt
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_pat  <= '0;
            err_cnt   <= '0;
        end else if (chk && mis) begin
            fail <= 1'b1;
            if (!fail) begin
                fail_addr <= addr;
                fail_pat  <= pat;
            end
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/bist_march_sequencer.sv
// bist_march_sequencer: write/read march over the memory with generator strobe control.
module bist_march_sequencer
    import bist_march_sequencer_pkg::*;
#(
    parameter int aw = `ADDR_WIDTH,
    parameter int dw = `DATA_WIDTH,
    parameter int np = NP_DEF,
    parameter int ew = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_in,
    output logic          busy_out,
    output logic          done_out,
    output logic          pass_out,
    output logic          gen_clr_out,
    output logic          sbmt_out,
    output logic          shft_out,
    output logic [aw-1:0] addr_out,
    input  logic [dw-1:0] ptrn_in,
    output logic          mem_we_out,
    output logic          mem_re_out,
    output logic [dw-1:0] mem_wdata_out,
    input  logic [dw-1:0] mem_rdata_in,
    output logic          fail_out,
    output logic [aw-1:0] fail_addr_out,
    output logic [7:0]    fail_pat_out,
    output logic [ew-1:0] err_cnt_out
);
    state_t        state, state_n;
    logic [aw-1:0] addr, addr_n;
    logic [2:0]    tm, tm_n, tm_inc;
    logic [7:0]    pat, pat_n;
    logic          ph, ph_n;
    logic [dw-1:0] exp_q;
    logic          go, last, wr;

    assign go     = (state == IDLE || state == DONE) && start_in;
    assign last   = addr == '1;
    assign wr     = state == W_ADV || state == W_PAD;
    assign tm_inc = (tm == 3'(TILE - 1)) ? 3'd0 : tm + 3'd1;

    // Pads keep the generator's tile count aligned with address 0 at the start of every pass.
    always_comb begin
        state_n = state;
        addr_n  = addr;
        tm_n    = tm;
        pat_n   = pat;
        ph_n    = ph;
        case (state)
            IDLE, DONE: if (start_in) begin
                state_n = CLR_H;
                addr_n  = '0;
                tm_n    = '0;
                pat_n   = '0;
                ph_n    = 1'b0;
            end
            CLR_H: state_n = CLR_L;
            CLR_L: state_n = W_ACC;
            W_ACC: state_n = W_ADV;
            R_ACC: state_n = R_CMP;
            W_ADV, R_CMP: begin
                addr_n  = addr + 1'b1;
                tm_n    = tm_inc;
                state_n = wr ? (last ? W_PAD : W_ACC) : (last ? R_PAD : R_ACC);
            end
            W_PAD, R_PAD: begin
                ph_n = ~ph & (tm != 3'd0);
                tm_n = ph ? tm_inc : tm;
                if (ph ? tm_inc == 3'd0 : tm == 3'd0) state_n = wr ? R_ACC : NEXT;
            end
            NEXT: begin
                state_n = (pat == 8'(np - 1)) ? DONE : W_ACC;
                pat_n   = (pat == 8'(np - 1)) ? pat : pat + 8'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            addr  <= '0;
            tm    <= '0;
            pat   <= '0;
            ph    <= 1'b0;
            exp_q <= '0;
        end else begin
            state <= state_n;
            addr  <= addr_n;
            tm    <= tm_n;
            pat   <= pat_n;
            ph    <= ph_n;
            if (state == R_ACC) exp_q <= ptrn_in;
        end
    end

    assign busy_out      = !(state == IDLE || state == DONE);
    assign done_out      = state == DONE;
    assign pass_out      = done_out & ~fail_out;
    assign gen_clr_out   = state == CLR_H;
    assign sbmt_out      = state == NEXT;
    assign shft_out      = state == W_ADV || state == R_CMP || ((state == W_PAD || state == R_PAD) && ph);
    assign addr_out      = addr;
    assign mem_we_out    = state == W_ACC;
    assign mem_re_out    = state == R_ACC;
    assign mem_wdata_out = mem_we_out ? ptrn_in : '0;

    bist_err_log #(.aw(aw), .ew(ew)) u_log (
        .clk       (clk),
        .rst       (rst),
        .clr       (go),
        .chk       (state == R_CMP),
        .mis       (mem_rdata_in != exp_q),
        .addr      (addr),
        .pat       (pat),
        .fail      (fail_out),
        .fail_addr (fail_addr_out),
        .fail_pat  (fail_pat_out),
        .err_cnt   (err_cnt_out)
    );
endmodule
